// File: rtl/vga_glyph_pkg.sv
// Shared constants for the glyph renderer: palette, 640x480 timing, sync polarity
// helper and the glyph bitmap function used by both the ROM and its reference model.
package vga_glyph_pkg;

  localparam logic [5:0] PALETTE [0:7] = '{
    6'b000000, 6'b000100, 6'b001000, 6'b001100,
    6'b011100, 6'b101101, 6'b111110, 6'b111111
  };

  localparam int H_VISIBLE    = 640;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 751;
  localparam int V_VISIBLE    = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 491;
  localparam int V_TOTAL      = 525;

  // Level a sync line rests at outside its pulse.
  function automatic logic sync_idle(input bit active_low);
    return active_low;
  endfunction

  // Procedural glyph set: a scrambled mix of index and row gives a dense,
  // index-dependent bit pattern without storing a table. Bit c is pixel column c.
  function automatic logic [15:0] glyph_word(input logic [7:0] idx, input logic [3:0] gy);
    logic [15:0] s;
    s = {idx, gy, 4'hA} ^ {gy, idx ^ 8'h5A, idx[3:0]};
    return s ^ {5'b0, s[15:5]};
  endfunction

endpackage

// File: rtl/vga_glyph_renderer_if.sv
// Video stream between the timing generator and the renderer: raster position and
// syncs in, colour and re-aligned syncs out.
interface vga_glyph_renderer_if;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       display_on;
  logic       hsync_in;
  logic       vsync_in;
  logic [5:0] rgb;
  logic       hsync_out;
  logic       vsync_out;

  modport master (
    output pix_x, pix_y, display_on, hsync_in, vsync_in,
    input  rgb, hsync_out, vsync_out
  );

  modport slave (
    input  pix_x, pix_y, display_on, hsync_in, vsync_in,
    output rgb, hsync_out, vsync_out
  );
endinterface

// File: rtl/glyph_rom_param.sv
// Combinational glyph ROM: one row word per (glyph index, glyph row).
// Rows past the cell height read as blank.
module glyph_rom_param
  import vga_glyph_pkg::*;
#(
  parameter int GLYPH_W    = 8,
  parameter int GLYPH_H    = 12,
  parameter int GLYPH_BITS = 5
) (
  input  logic [GLYPH_BITS-1:0] idx,
  input  logic [3:0]            gy,
  output logic [GLYPH_W-1:0]    word
);

  localparam logic [4:0] ROWS = 5'(GLYPH_H);

  assign word = ({1'b0, gy} < ROWS) ? GLYPH_W'(glyph_word(8'(idx), gy)) : '0;

endmodule

// File: rtl/vga_glyph_renderer.sv
// Glyph-mode pixel pipeline: incremental cell counters, per-frame animation and
// frame-latched palette, two-stage registered output with matching sync delay.
module vga_glyph_renderer
  import vga_glyph_pkg::*;
#(
  parameter int GLYPH_W         = 8,
  parameter int GLYPH_H         = 12,
  parameter int GLYPH_BITS      = 5,
  parameter int LINE_END_X      = 639,
  parameter int FRAME_END_Y     = 524,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vga_glyph_renderer_if.slave   vid,
  input  logic [2:0]            cfg_fg,
  input  logic [2:0]            cfg_bg,
  input  logic [1:0]            cfg_speed,
  input  logic                  cfg_freeze
);

  localparam int         XW      = $clog2(GLYPH_W);
  localparam int         STAGES  = 2;
  localparam logic       IDLE    = sync_idle(SYNC_ACTIVE_LOW);
  localparam logic [9:0] X_END   = 10'(LINE_END_X);
  localparam logic [9:0] Y_END   = 10'(FRAME_END_Y);
  localparam logic [3:0] GY_LAST = 4'(GLYPH_H - 1);

  logic [3:0]            gy;
  logic [5:0]            row;
  logic [9:0]            fcnt;
  logic [2:0]            fg_l, bg_l;
  logic [1:0]            speed_l;
  logic                  vs_prev;
  logic                  frame_ev;
  logic                  anim;
  logic [GLYPH_BITS-1:0] row_rot, idx;
  logic [GLYPH_W-1:0]    rom_word, word1;
  logic [XW-1:0]         gx1;
  logic                  de1;
  logic [STAGES:1]       hs_pipe, vs_pipe;
  logic [5:0]            rgb_q;

  // Stage 0: cell index from the x bit slice and the tracked text row.
  assign frame_ev = (vid.vsync_in != IDLE) && (vs_prev == IDLE);
  assign anim     = fcnt[speed_l];
  assign row_rot  = {row[GLYPH_BITS-2:0], row[GLYPH_BITS-1]};
  assign idx      = vid.pix_x[XW +: GLYPH_BITS] ^ row_rot ^ GLYPH_BITS'(anim);

  glyph_rom_param #(
    .GLYPH_W    (GLYPH_W),
    .GLYPH_H    (GLYPH_H),
    .GLYPH_BITS (GLYPH_BITS)
  ) u_rom (
    .idx  (idx),
    .gy   (gy),
    .word (rom_word)
  );

  // Row tracking replaces pix_y / GLYPH_H; frame end takes priority over row wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gy  <= '0;
      row <= '0;
    end else if (vid.pix_x == X_END) begin
      if (vid.pix_y == Y_END) begin
        gy  <= '0;
        row <= '0;
      end else if (gy == GY_LAST) begin
        gy  <= '0;
        row <= row + 6'd1;
      end else begin
        gy  <= gy + 4'd1;
      end
    end
  end

  // Config is only sampled at the frame event so a frame never changes colour midway.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_prev <= IDLE;
      fcnt    <= '0;
      fg_l    <= 3'd7;
      bg_l    <= 3'd0;
      speed_l <= 2'd0;
    end else begin
      vs_prev <= vid.vsync_in;
      if (frame_ev) begin
        fg_l    <= cfg_fg;
        bg_l    <= cfg_bg;
        speed_l <= cfg_speed;
        if (!cfg_freeze) fcnt <= fcnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word1   <= '0;
      gx1     <= '0;
      de1     <= 1'b0;
      hs_pipe <= {STAGES{IDLE}};
      vs_pipe <= {STAGES{IDLE}};
      rgb_q   <= '0;
    end else begin
      word1   <= rom_word;
      gx1     <= vid.pix_x[XW-1:0];
      de1     <= vid.display_on;
      hs_pipe <= {hs_pipe[STAGES-1:1], vid.hsync_in};
      vs_pipe <= {vs_pipe[STAGES-1:1], vid.vsync_in};
      rgb_q   <= !de1 ? 6'd0 : (word1[gx1] ? PALETTE[fg_l] : PALETTE[bg_l]);
    end
  end

  assign vid.rgb       = rgb_q;
  assign vid.hsync_out = hs_pipe[STAGES];
  assign vid.vsync_out = vs_pipe[STAGES];

endmodule
